// File: rtl/vtc_detect.sv
// Sink-side video timing detector: recovers pixel X/Y, measures active size, reports lock/err.
// Optional macro VTD_EXPECT_CHECK_EN: only frames matching EXP_ACTIVE_X/EXP_ACTIVE_Y count as good.
module vtc_detect #(
   parameter int COUNTER_WIDTH = 10,
   parameter int LOCK_FRAMES   = 2,
   parameter int EXP_ACTIVE_X  = 640,
   parameter int EXP_ACTIVE_Y  = 480
) (
   input  logic                     i_clk,
   input  logic                     i_rstn,
   input  logic                     i_hsync,
   input  logic                     i_vsync,
   input  logic                     i_active,
   output logic                     o_active,
   output logic [COUNTER_WIDTH-1:0] o_x,
   output logic [COUNTER_WIDTH-1:0] o_y,
   output logic                     o_sof,
   output logic                     o_eol,
   output logic [COUNTER_WIDTH-1:0] o_width,
   output logic [COUNTER_WIDTH-1:0] o_height,
   output logic                     o_locked,
   output logic                     o_err
);
   localparam int CW = COUNTER_WIDTH;
   localparam int MW = $clog2(LOCK_FRAMES + 1);
   localparam logic [CW-1:0] CMAX = '1;

   typedef enum logic [1:0] {SEEK, MEASURE, LOCKED} state_t;

   state_t          state, state_n;
   logic [MW-1:0]   match_cnt, match_n;
   logic            err_n;

   logic            hs_r1, hs_r2, vs_r1, vs_r2, act_r1, act_r2;
   logic [CW-1:0]   xcnt, ycnt, fw;
   logic            frame_bad, hs_seen, sof_armed;

   logic            act_rise, act_fall, vs_rise, hs_rise;
   logic            x_sat, y_sat, hs_bad, line_bad, bad_now;
   logic            good, same_dims, exp_ok;
   logic [CW-1:0]   fw_cur, fh_cur;

   assign act_rise = act_r1 & ~act_r2;
   assign act_fall = ~act_r1 & act_r2;
   assign vs_rise  = vs_r1 & ~vs_r2;
   assign hs_rise  = hs_r1 & ~hs_r2;

   assign x_sat    = act_r1 && (xcnt == CMAX);
   assign y_sat    = act_fall && (ycnt == CMAX);
   assign hs_bad   = act_rise & ~hs_seen;
   assign line_bad = act_fall && (ycnt != '0) && (xcnt != fw);
   assign bad_now  = frame_bad | x_sat | y_sat | hs_bad | line_bad;

   // A line ending in the same cycle as vsync rise is folded into this frame.
   assign fw_cur = (act_fall && ycnt == '0) ? xcnt : fw;
   assign fh_cur = (act_fall && !y_sat) ? ycnt + 1'b1 : ycnt;

`ifdef VTD_EXPECT_CHECK_EN
   assign exp_ok = (fw_cur == CW'(EXP_ACTIVE_X)) && (fh_cur == CW'(EXP_ACTIVE_Y));
`else
   assign exp_ok = 1'b1;
`endif

   assign good      = ~bad_now && (fh_cur != '0) && exp_ok;
   assign same_dims = (fw_cur == o_width) && (fh_cur == o_height);

   // input pipeline and measurement counters
   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         {hs_r1, hs_r2, vs_r1, vs_r2, act_r1, act_r2} <= '0;
         xcnt      <= '0;
         ycnt      <= '0;
         fw        <= '0;
         frame_bad <= 1'b0;
         hs_seen   <= 1'b0;
         sof_armed <= 1'b0;
      end else begin
         hs_r1  <= i_hsync;
         hs_r2  <= hs_r1;
         vs_r1  <= i_vsync;
         vs_r2  <= vs_r1;
         act_r1 <= i_active;
         act_r2 <= act_r1;

         if (!act_r1)    xcnt <= '0;
         else if (!x_sat) xcnt <= xcnt + 1'b1;

         if (vs_rise) begin
            ycnt      <= '0;
            fw        <= '0;
            frame_bad <= 1'b0;
         end else begin
            if (act_fall && !y_sat) ycnt <= ycnt + 1'b1;
            fw        <= fw_cur;
            frame_bad <= bad_now;
         end

         // hsync only qualifies: each active run must be preceded by a pulse
         if (act_rise)     hs_seen <= 1'b0;
         else if (hs_rise) hs_seen <= 1'b1;

         if (vs_rise)       sof_armed <= 1'b1;
         else if (act_rise) sof_armed <= 1'b0;
      end
   end

   // outputs aligned two cycles after the inputs
   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         o_active <= 1'b0;
         o_x      <= '0;
         o_y      <= '0;
         o_sof    <= 1'b0;
         o_eol    <= 1'b0;
         o_width  <= '0;
         o_height <= '0;
         o_locked <= 1'b0;
         o_err    <= 1'b0;
      end else begin
         o_active <= act_r1;
         o_x      <= xcnt;
         o_y      <= ycnt;
         o_sof    <= act_rise & sof_armed;
         o_eol    <= act_r1 & ~i_active;
         if (vs_rise && state != SEEK) begin
            o_width  <= fw_cur;
            o_height <= fh_cur;
         end
         o_locked <= (state_n == LOCKED);
         o_err    <= err_n;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         state     <= SEEK;
         match_cnt <= '0;
      end else begin
         state     <= state_n;
         match_cnt <= match_n;
      end
   end

   always_comb begin
      state_n = state;
      match_n = match_cnt;
      err_n   = 1'b0;
      if (vs_rise) begin
         case (state)
            SEEK: begin
               state_n = MEASURE;
               match_n = '0;
            end
            MEASURE: begin
               if (good && (match_cnt == '0 || same_dims)) match_n = match_cnt + 1'b1;
               else                                     match_n = good ? MW'(1) : '0;
               if (match_n == MW'(LOCK_FRAMES)) state_n = LOCKED;
            end
            LOCKED: begin
               if (!good || !same_dims) begin
                  err_n   = 1'b1;
                  state_n = MEASURE;
                  match_n = good ? MW'(1) : '0;
               end
            end
            default: begin
               state_n = SEEK;
               match_n = '0;
            end
         endcase
      end
   end
endmodule
